rgmii_rx_ctrl: RTL

- Receive-side sequencer for the RGMII port.
- Consumes the registered rising/falling-edge samples from the five DDR input pads (RXD[3:0], RX_CTL) and assembles one byte per clkrx cycle.
- Strips preamble/SFD, delimits frames, flags errors and decodes in-band link status.
- Emits a framed byte stream with no backpressure to the MAC-side logic, plus saturating frame/error statistics.

---
 rtl/rgmii_pkg.sv | 21 ++
 rtl/rgmii_sat_cnt.sv | 20 ++
 rtl/rgmii_rx_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive path.
package rgmii_pkg;

  // Receive sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_t;

  // Preamble and start-of-frame delimiter bytes as seen after nibble assembly
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  // In-band link speed codes carried on RXD[2:1] between frames
  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1G   = 2'b10;

endpackage

// File: rtl/rgmii_sat_cnt.sv
// Saturating event counter used for the receive statistics.
module rgmii_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  // Count up on inc and stick at all-ones so a wrapped count never looks small
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      value <= '0;
    end else if (inc && (value != {CNT_W{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/rgmii_rx_ctrl.sv
// RGMII receive sequencer: assembles bytes from DDR pad samples, strips the
// preamble/SFD, delimits frames through a one-byte hold register so the last
// byte can carry eop, flags bad frames and tracks in-band link status.
module rgmii_rx_ctrl
  import rgmii_pkg::*;
#(
  parameter int MAX_LEN = 1536,
  parameter int MAX_PRE = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clkrx,
  input  logic             rstn,
  input  logic             en,
  input  logic [3:0]       rxd_rise,
  input  logic [3:0]       rxd_fall,
  input  logic             rxctl_rise,
  input  logic             rxctl_fall,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_sop,
  output logic             m_eop,
  output logic             m_err,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             link_fdx,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PRE_W = $clog2(MAX_PRE + 1);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [7:0] byte_in;
  logic       dv;
  logic       er;

  rx_state_t  state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       err_flag_q, err_flag_d;
  logic       trunc_q, trunc_d;
  logic       sop_pend_q, sop_pend_d;

  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic       out_err;
  logic       link_load;
  logic       drop_err;
  logic       frame_inc;
  logic       err_inc;

  // The rising-edge nibble is the low half of the byte; RX_CTL carries DV and DV^ER
  always_comb begin
    byte_in = {rxd_fall, rxd_rise};
    dv      = rxctl_rise;
    er      = rxctl_rise ^ rxctl_fall;
  end

  // Sequencer state and per-frame bookkeeping registers
  always_ff @(posedge clkrx or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      err_flag_q   <= 1'b0;
      trunc_q      <= 1'b0;
      sop_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      err_flag_q   <= err_flag_d;
      trunc_q      <= trunc_d;
      sop_pend_q   <= sop_pend_d;
    end
  end

  // Next-state logic; the held byte is released one cycle later so its eop is known
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    err_flag_d   = err_flag_q;
    trunc_d      = trunc_q;
    sop_pend_d   = sop_pend_q;
    out_valid    = 1'b0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    out_err      = 1'b0;
    link_load    = 1'b0;
    drop_err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!dv && !er && (rxd_rise == rxd_fall)) begin
          link_load = 1'b1;
        end
        if (dv && en) begin
          pre_cnt_d    = PRE_W'(1);
          byte_cnt_d   = '0;
          hold_valid_d = 1'b0;
          err_flag_d   = 1'b0;
          trunc_d      = 1'b0;
          sop_pend_d   = 1'b1;
          if (byte_in == PRE_BYTE) begin
            state_d = PRE;
          end else if (byte_in == SFD_BYTE) begin
            state_d = DATA;
          end else begin
            state_d  = DROP;
            drop_err = 1'b1;
          end
        end
      end

      PRE: begin
        if (!dv) begin
          state_d  = IDLE;
          drop_err = 1'b1;
        end else if (byte_in == PRE_BYTE) begin
          if (pre_cnt_q == PRE_W'(MAX_PRE)) begin
            state_d  = DROP;
            drop_err = 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
          end
        end else if (byte_in == SFD_BYTE) begin
          state_d = DATA;
        end else begin
          state_d  = DROP;
          drop_err = 1'b1;
        end
      end

      DATA: begin
        if (trunc_q) begin
          out_valid    = 1'b1;
          out_sop      = sop_pend_q;
          out_eop      = 1'b1;
          out_err      = 1'b1;
          sop_pend_d   = 1'b0;
          hold_valid_d = 1'b0;
          trunc_d      = 1'b0;
          state_d      = dv ? DROP : IDLE;
        end else if (dv) begin
          if (er) begin
            err_flag_d = 1'b1;
          end
          if (hold_valid_q) begin
            out_valid  = 1'b1;
            out_sop    = sop_pend_q;
            sop_pend_d = 1'b0;
          end
          hold_d       = byte_in;
          hold_valid_d = 1'b1;
          byte_cnt_d   = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LEN_W'(MAX_LEN - 1)) begin
            trunc_d = 1'b1;
          end
        end else begin
          if (hold_valid_q) begin
            out_valid = 1'b1;
            out_sop   = sop_pend_q;
            out_eop   = 1'b1;
            out_err   = err_flag_q | er;
          end
          sop_pend_d   = 1'b0;
          hold_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      DROP: begin
        if (!dv) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered stream outputs; data reads zero whenever no byte is presented
  always_ff @(posedge clkrx or negedge rstn) begin
    if (!rstn) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      m_data  <= out_valid ? hold_q : 8'h00;
      m_valid <= out_valid;
      m_sop   <= out_sop;
      m_eop   <= out_eop;
      m_err   <= out_err;
    end
  end

  // Link status is only refreshed from a clean inter-frame symbol
  always_ff @(posedge clkrx or negedge rstn) begin
    if (!rstn) begin
      link_up    <= 1'b0;
      link_speed <= SPEED_10M;
      link_fdx   <= 1'b0;
    end else if (link_load) begin
      link_up    <= rxd_rise[0];
      link_speed <= rxd_rise[2:1];
      link_fdx   <= rxd_rise[3];
    end
  end

  // Statistics events: good eop, bad eop, or an abort before the payload started
  always_comb begin
    frame_inc = out_valid & out_eop & ~out_err;
    err_inc   = (out_valid & out_eop & out_err) | drop_err;
  end

  rgmii_sat_cnt #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk   (clkrx),
    .clr_n (rstn),
    .inc   (frame_inc),
    .value (frame_cnt)
  );

  rgmii_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clkrx),
    .clr_n (rstn),
    .inc   (err_inc),
    .value (err_cnt)
  );

endmodule
